// File: rtl/draw_scheduler.sv
// Per-frame scheduler that hands the single VGA framebuffer write port to N_REQ sprite engines in fixed index order.
// Optional grant watchdog enabled by defining DRAW_SCHED_WDOG_EN.
module draw_scheduler #(
    parameter int N_REQ       = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int C_W         = 3,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    input  logic [N_REQ*X_W-1:0]   px_x,
    input  logic [N_REQ*Y_W-1:0]   px_y,
    input  logic [N_REQ*C_W-1:0]   px_c,
    input  logic [N_REQ-1:0]       px_we,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       start,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_color,
    output logic                   vga_we,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   wdog_abort
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [N_REQ-1:0]  pending;
    logic [SEL_W-1:0]  sel;

    logic [SEL_W-1:0]  first_idx;
    logic [N_REQ-1:0]  first_oh;
    logic              first_found;

    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [C_W-1:0]    cur_c;
    logic              cur_we;
    logic              cur_done;
    logic              wdog_hit;

    // Lowest set index of the snapshot wins; index 0 (erase) always goes first.
    always_comb begin
        first_idx   = '0;
        first_oh    = '0;
        first_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i] && !first_found) begin
                first_idx   = SEL_W'(i);
                first_oh[i] = 1'b1;
                first_found = 1'b1;
            end
        end
    end

    // Engine-to-port mux: only the selected engine's stream and done are visible.
    always_comb begin
        cur_x    = '0;
        cur_y    = '0;
        cur_c    = '0;
        cur_we   = 1'b0;
        cur_done = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_x    = px_x[i*X_W +: X_W];
                cur_y    = px_y[i*Y_W +: Y_W];
                cur_c    = px_c[i*C_W +: C_W];
                cur_we   = px_we[i];
                cur_done = done[i];
            end
        end
    end

`ifdef DRAW_SCHED_WDOG_EN
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WD_W-1:0] wdog_cnt;

    assign wdog_hit = (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

    // Counts RUN cycles of the current grant; a hit without done revokes the grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_cnt   <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= (state == S_RUN) && wdog_hit && !cur_done;
            if (state == S_START) begin
                wdog_cnt <= '0;
            end else if (state == S_RUN) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end
`else
    assign wdog_hit   = 1'b0;
    assign wdog_abort = 1'b0;

    if (WDOG_CYCLES < 2) begin : g_wdog_cycles_unused
    end
`endif

    // Engine handshake: grant is held from the start pulse until the cycle after
    // done[sel] (or a watchdog hit); start is a single-cycle pulse in the first
    // granted cycle, and done from any engine other than sel is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pending    <= '0;
            sel        <= '0;
            grant      <= '0;
            start      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_color  <= '0;
            vga_we     <= 1'b0;
        end else begin
            start      <= '0;
            frame_done <= 1'b0;
            overrun    <= frame_tick && (state != S_IDLE);

            vga_x      <= cur_x;
            vga_y      <= cur_y;
            vga_color  <= cur_c;
            vga_we     <= cur_we && (state == S_RUN);

            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        pending <= req;
                        busy    <= 1'b1;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!first_found) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        sel   <= first_idx;
                        grant <= first_oh;
                        start <= first_oh;
                        state <= S_START;
                    end
                end
                S_START: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (cur_done || wdog_hit) begin
                        pending[sel] <= 1'b0;
                        grant        <= '0;
                        state        <= S_SCAN;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed frame scenarios plus randomized traffic checked every cycle
// against a queue-based frame model. Define DRAW_SCHED_WDOG_EN to also exercise the watchdog.
module tb_draw_scheduler;

    localparam int N_REQ = 4;
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int C_W   = 3;
    localparam int WDOG  = 16;
    localparam int PX_W  = X_W + Y_W + C_W;
`ifdef DRAW_SCHED_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic                  clk;
    logic                  reset_n;
    logic                  frame_tick;
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      done;
    logic [N_REQ*X_W-1:0]  px_x;
    logic [N_REQ*Y_W-1:0]  px_y;
    logic [N_REQ*C_W-1:0]  px_c;
    logic [N_REQ-1:0]      px_we;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      start;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [C_W-1:0]        vga_color;
    logic                  vga_we;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;
    logic                  wdog_abort;

    draw_scheduler #(
        .N_REQ(N_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .req(req), .done(done),
        .px_x(px_x), .px_y(px_y), .px_c(px_c), .px_we(px_we),
        .grant(grant), .start(start), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
        .vga_we(vga_we), .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .wdog_abort(wdog_abort)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    // A pass is: one dead scan cycle, then for each engine left in the snapshot a
    // start cycle followed by run cycles until its done; an empty list yields one
    // frame_done cycle before the scheduler is idle again.
    bit   m_active = 1'b0;
    bit   m_scan   = 1'b0;
    bit   m_fd     = 1'b0;
    bit   m_stcyc  = 1'b0;
    int   m_owner  = -1;
    int   m_run    = 0;
    int   m_todo[$];
    logic [PX_W-1:0] exp_q[$];

    logic [N_REQ-1:0] e_grant = '0;
    logic [N_REQ-1:0] e_start = '0;
    logic e_busy = 1'b0, e_fd = 1'b0, e_ovr = 1'b0, e_we = 1'b0, e_abort = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_active = 1'b0; m_scan = 1'b0; m_fd = 1'b0; m_stcyc = 1'b0;
            m_owner = -1; m_run = 0;
            m_todo.delete();
            exp_q.delete();
            e_ovr = 1'b0; e_we = 1'b0; e_abort = 1'b0;
        end else begin
            e_ovr   = frame_tick && m_active;
            e_we    = (m_owner >= 0) && !m_stcyc && px_we[m_owner];
            e_abort = 1'b0;
            if (e_we)
                exp_q.push_back({px_x[m_owner*X_W +: X_W], px_y[m_owner*Y_W +: Y_W],
                                 px_c[m_owner*C_W +: C_W]});
            if (!m_active) begin
                if (frame_tick) begin
                    for (int i = 0; i < N_REQ; i++)
                        if (req[i]) m_todo.push_back(i);
                    m_active = 1'b1;
                    m_scan   = 1'b1;
                end
            end else if (m_scan) begin
                m_scan = 1'b0;
                if (m_todo.size() == 0) begin
                    m_fd = 1'b1;
                end else begin
                    m_owner = m_todo.pop_front();
                    m_stcyc = 1'b1;
                    m_run   = 0;
                end
            end else if (m_fd) begin
                m_fd     = 1'b0;
                m_active = 1'b0;
            end else if (m_stcyc) begin
                m_stcyc = 1'b0;
            end else if (m_owner >= 0) begin
                m_run++;
                if (done[m_owner] || (WD_ON && m_run == WDOG)) begin
                    e_abort = !done[m_owner];
                    m_owner = -1;
                    m_scan  = 1'b1;
                end
            end
        end
        e_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_start = m_stcyc ? e_grant : 4'b0000;
        e_busy  = m_active;
        e_fd    = m_fd;
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("grant",      32'(grant),      32'(e_grant));
            check("start",      32'(start),      32'(e_start));
            check("busy",       32'(busy),       32'(e_busy));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("overrun",    32'(overrun),    32'(e_ovr));
            check("wdog_abort", 32'(wdog_abort), 32'(e_abort));
            check("vga_we",     32'(vga_we),     32'(e_we));
            if (e_we) begin
                if (exp_q.size() == 0) begin
                    check("vga_pixel_queue", 32'(0), 32'(1));
                end else begin
                    check("vga_pixel", 32'({vga_x, vga_y, vga_color}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_tick = 1'b0; req = '0; done = '0; px_we = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        check_en = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    task automatic tick(input logic [N_REQ-1:0] r);
        req = r; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic rand_cycle();
        frame_tick = ($urandom_range(0, 19) == 0);
        req        = N_REQ'($urandom_range(0, 15));
        for (int i = 0; i < N_REQ; i++) done[i] = ($urandom_range(0, 4) == 0);
        px_x       = {$urandom, $urandom};
        px_y       = {$urandom, $urandom};
        px_c       = N_REQ*C_W'($urandom);
        px_we      = N_REQ'($urandom_range(0, 15));
        reset_n    = ($urandom_range(0, 399) != 0);
        step();
    endtask

    logic [N_REQ-1:0] grant_seen;

    initial begin
        px_x = '0; px_y = '0; px_c = '0;
        do_reset();
        check("reset_grant", 32'(grant), 32'(0));
        check("reset_busy",  32'(busy),  32'(0));

        // Two engines, odd indices: start[1] two cycles after tick, then start[3].
        tick(4'b1010);
        grant_seen = grant;
        step();
        check("s1_first_start", 32'(start), 32'(4'b0010));
        grant_seen |= grant;
        step();
        px_x[1*X_W +: X_W] = 10'd5; px_y[1*Y_W +: Y_W] = 10'd7; px_c[1*C_W +: C_W] = 3'b101;
        px_x[2*X_W +: X_W] = 10'd9; px_we = 4'b0010;
        grant_seen |= grant;
        step();
        check("s2_vga_we", 32'(vga_we),    32'(1));
        check("s2_vga_x",  32'(vga_x),     32'(5));
        check("s2_vga_y",  32'(vga_y),     32'(7));
        check("s2_vga_c",  32'(vga_color), 32'(5));
        px_we = 4'b0100; done = 4'b0010;
        grant_seen |= grant;
        step();
        check("s2_ungranted_we", 32'(vga_we), 32'(0));
        done = '0; px_we = '0;
        grant_seen |= grant;
        step();
        check("s1_second_start", 32'(start), 32'(4'b1000));
        grant_seen |= grant;
        step();
        done = 4'b1000;
        step();
        done = '0;
        step();
        check("s1_frame_done", 32'(frame_done), 32'(1));
        check("s1_grants_used", 32'(grant_seen), 32'(4'b1010));
        step();

        // Empty snapshot, then an overrun tick during a grant.
        tick(4'b0000);
        step();
        check("s3_empty_fd", 32'(frame_done), 32'(1));
        check("s3_empty_grant", 32'(grant), 32'(0));
        step();
        tick(4'b0001);
        step();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("s3_overrun", 32'(overrun), 32'(1));
        step();
        check("s3_overrun_pulse", 32'(overrun), 32'(0));
        check("s3_still_granted", 32'(grant), 32'(4'b0001));
        done = 4'b0001;
        step();
        done = '0;
        step();
        check("s3_pass_done", 32'(frame_done), 32'(1));
        step();

        // Snapshot holds after req drops; foreign done ignored.
        tick(4'b0100);
        req = '0;
        step();
        check("s4_start2", 32'(start), 32'(4'b0100));
        step();
        done = 4'b0001;
        step();
        done = '0;
        check("s4_foreign_done", 32'(grant), 32'(4'b0100));
        done = 4'b0100;
        step();
        done = '0;
        step();
        check("s4_frame_done", 32'(frame_done), 32'(1));
        step();

        // Reset in the middle of a grant, then a fresh pass from the lowest index.
        tick(4'b0011);
        step();
        step();
        px_we = 4'b0001;
        step();
        reset_n = 1'b0;
        step();
        check("s5_rst_grant", 32'(grant),  32'(0));
        check("s5_rst_we",    32'(vga_we), 32'(0));
        check("s5_rst_busy",  32'(busy),   32'(0));
        reset_n = 1'b1; px_we = '0;
        tick(4'b0101);
        step();
        check("s5_restart", 32'(start), 32'(4'b0001));
`ifdef DRAW_SCHED_WDOG_EN
        do_reset();
        tick(4'b0011);
        step();
        for (int i = 0; i < WDOG; i++) step();
        check("s6_wdog_abort", 32'(wdog_abort), 32'(1));
        check("s6_wdog_grant", 32'(grant), 32'(0));
        step();
        check("s6_next_start", 32'(start), 32'(4'b0010));
`endif

        for (int n = 0; n < 4000; n++) rand_cycle();
        reset_n = 1'b1;
        idle_inputs();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
